vector_sweep_ctrl: RTL
======================

VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

Interface
REQ-001 Parameter N_IN, default 3: width of the stimulus vector driven to the DUT; the sweep covers 2^N_IN vectors.
REQ-002 Parameter SETTLE, default 1: clock cycles between applying a vector and sampling the DUT response; a value of 0 SHALL behave as 1.
REQ-003 CK  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset; reset=0 SHALL reset the block immediately.
REQ-005 start  input  1: starts a sweep; it SHALL be sampled only in IDLE.
REQ-006 abort  input  1: terminates a sweep; it SHALL be honoured in SETTLE and EMIT.
REQ-007 vec_out  output  N_IN: registered stimulus vector driven to the DUT inputs.
REQ-008 dut_out  input  1: DUT response bit.
REQ-009 rec_valid  output  1: a captured record is available.
REQ-010 rec_ready  input  1: the consumer accepts the record.
REQ-011 rec_vec  output  N_IN: vector of the current record.
REQ-012 rec_resp  output  1: captured response of the current record.
REQ-013 busy  output  1: high while in SETTLE or EMIT.
REQ-014 done  output  1: one-cycle pulse when a sweep completes.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, EMIT and DONE.
REQ-016 IDLE, start=1 at an edge SHALL give: vec_out<=0, settle counter<=0, state->SETTLE.
REQ-017 SETTLE SHALL last SETTLE cycles.
REQ-018 At the last SETTLE edge the block SHALL set rec_resp<=dut_out, rec_vec<=vec_out, rec_valid<=1 and state->EMIT.
REQ-019 rec_valid SHALL rise SETTLE edges after the edge that sampled start, or SETTLE edges after the previous handshake.
REQ-020 EMIT SHALL hold rec_valid, rec_vec, rec_resp and vec_out stable while rec_ready=0.
REQ-021 An EMIT edge with rec_ready=1 is a handshake: the block SHALL clear rec_valid.
REQ-022 On a handshake with vec_out=2^N_IN-1, state SHALL go to DONE.
REQ-023 On any other handshake the block SHALL set vec_out<=vec_out+1, clear the settle counter and go to SETTLE.
REQ-024 Vectors SHALL be emitted in strictly ascending order with no repeat or skip; vec_out SHALL NOT wrap inside a sweep.
REQ-025 DONE SHALL assert done for exactly one cycle and go to IDLE unconditionally; start sampled in DONE SHALL be ignored.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 at an edge in SETTLE or EMIT SHALL give: state->IDLE, rec_valid<=0, vec_out<=0, no done pulse.
REQ-028 abort SHALL take priority over a simultaneous handshake.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 With rec_ready tied high, each vector SHALL take SETTLE+1 cycles; a full sweep SHALL take 2^N_IN*(SETTLE+1) edges from the start edge to the final handshake.
REQ-031 The response SHALL be sampled only at the capture edge; changes on dut_out at any other time SHALL be ignored.

Reset
REQ-032 While reset=0: state=IDLE, vec_out=0, rec_vec=0, rec_resp=0, rec_valid=0, busy=0, done=0, counters=0.
REQ-033 reset asserted mid-sweep SHALL discard all progress; after release the block SHALL wait for a new start.
REQ-034 The first edge after reset release SHALL be able to sample start.

Verification
REQ-035 N_IN=3, SETTLE=1, rec_ready=1, start at edge k -> 8 records, rec_vec 000..111 in order, rec_resp equal to the DUT truth table; final handshake at k+16; done high for the single cycle after k+16.
REQ-036 rec_ready=0 for 5 cycles while rec_vec=011 -> rec_valid=1 and rec_vec, rec_resp, vec_out stable throughout; sweep resumes with 100 after rec_ready returns to 1.
REQ-037 SETTLE=3, rec_ready=1 -> rec_valid rises 3 edges after the start edge; full sweep of 32 edges; a dut_out glitch between capture edges does not appear in rec_resp.
REQ-038 abort asserted in the same cycle as a handshake on vec 101 -> next state IDLE, rec_valid=0, vec_out=000, no done pulse.
REQ-039 reset=0 asynchronously mid-SETTLE on vec 010 -> outputs zero immediately without a clock edge; after release a new start sweeps again from 000.
REQ-040 start pulsed during EMIT and during DONE -> ignored; exactly one sweep and one done pulse.

Source files
------------

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input sweep controller: steps a stimulus vector through all
// 2^N_IN codes, waits a settle time, captures the DUT response as a record.
module vector_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            CK,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_out,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [N_IN-1:0] rec_vec,
  output logic            rec_resp,
  output logic            busy,
  output logic            done
);

  // A settle time of zero is treated as one cycle.
  localparam int SET_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW = (SET_EFF > 1) ? $clog2(SET_EFF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SET_EFF - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] r_rec_vec;
  logic            r_rec_resp;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_vec      <= '0;
      r_rec_vec  <= '0;
      r_rec_resp <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_rec_resp <= dut_out;
            r_rec_vec  <= r_vec;
            r_valid    <= 1'b1;
            r_state    <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          // abort wins over a handshake in the same cycle
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (rec_ready) begin
            r_valid <= 1'b0;
            if (r_vec == VEC_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec   <= r_vec + 1'b1;
              r_cnt   <= '0;
              r_state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vec_out   = r_vec;
  assign rec_valid = r_valid;
  assign rec_vec   = r_rec_vec;
  assign rec_resp  = r_rec_resp;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
